// File: rtl/window_fetcher.sv
// window_fetcher: source-side read engine for the zoom coprocessor.
//
// The engine scans the source image in the synchronous pixel ROM as square blocks
// of 1x1, 2x2 or 4x4 pixels. It issues one ROM address per cycle and adds the
// returned pixels into a per-block sum. It then presents one window per block over
// a valid/ready handshake. It does not prefetch: the next block is fetched only
// after the current window has been accepted.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        asynchronous active-low reset
//   START        frame start, sampled only while idle
//   SHIFT_FACTOR block side = 1 << SHIFT_FACTOR (3 is treated as 2), latched at START
//   PIXEL_IN     ROM read data
//   R_ADDR       ROM read address (registered)
//   WIN_SUM      sum of all pixels in the block
//   WIN_FIRST    top-left pixel of the block
//   WIN_X/WIN_Y  block column / row index
//   WIN_VALID    window available
//   WIN_READY    consumer accepts the window
//   BUSY         frame in progress
//   DONE         one-cycle pulse after the last window is accepted
module window_fetcher #(
  parameter int unsigned SRC_WIDTH  = 160,
  parameter int unsigned SRC_HEIGHT = 120,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [1:0]        SHIFT_FACTOR,
  input  logic [7:0]        PIXEL_IN,
  output logic [ADDR_W-1:0] R_ADDR,
  output logic [11:0]       WIN_SUM,
  output logic [7:0]        WIN_FIRST,
  output logic [7:0]        WIN_X,
  output logic [6:0]        WIN_Y,
  output logic              WIN_VALID,
  input  logic              WIN_READY,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StPresent} state_e;

  state_e            state_q;
  logic [1:0]        shift_q;
  logic [2:0]        dx_q, dy_q;
  logic [7:0]        bx_q;
  logic [6:0]        by_q;
  logic [ADDR_W-1:0] col_base_q;   // bx * S
  logic [ADDR_W-1:0] blk_row_q;    // by * S * SRC_WIDTH
  logic [ADDR_W-1:0] row_q;        // (by * S + dy) * SRC_WIDTH
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LATENCY:0] tag_q;      // one bit per address in flight through the ROM
  logic [11:0]       acc_q;
  logic [7:0]        first_q;
  logic              first_pend_q;
  logic [11:0]       win_sum_q;
  logic [7:0]        win_first_q;
  logic [7:0]        win_x_q;
  logic [6:0]        win_y_q;
  logic              win_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [2:0]        side_m1;
  logic [ADDR_W-1:0] side_a;
  logic [ADDR_W-1:0] row_stride;
  logic [ADDR_W-1:0] blk_stride;
  logic [7:0]        cols_last;
  logic [6:0]        rows_last;
  logic              last_issue;
  logic              last_col;
  logic              last_row;
  logic              pix_vld;
  logic              drain_done;
  logic [11:0]       sum_nxt;
  logic [7:0]        first_nxt;
  logic [ADDR_W-1:0] col_nxt;
  logic [ADDR_W-1:0] blk_nxt;
  logic              issue;

  // Block geometry derived from the latched shift; shifts and adds only.
  always_comb begin
    side_m1 = 3'd0;
    case (shift_q)
      2'd1:    side_m1 = 3'd1;
      2'd2:    side_m1 = 3'd3;
      default: side_m1 = 3'd0;
    endcase
    side_a     = ADDR_W'(side_m1) + ADDR_W'(1);
    row_stride = ADDR_W'(SRC_WIDTH);
    blk_stride = row_stride << shift_q;
    cols_last  = 8'((SRC_WIDTH >> shift_q) - 1);
    rows_last  = 7'((SRC_HEIGHT >> shift_q) - 1);
  end

  always_comb begin
    last_issue = (dx_q == side_m1) && (dy_q == side_m1);
    last_col   = (bx_q == cols_last);
    last_row   = (by_q == rows_last);
    pix_vld    = tag_q[RD_LATENCY];
    // The last sample is the one emerging with nothing younger behind it.
    drain_done = pix_vld && (tag_q[RD_LATENCY-1:0] == '0);
    sum_nxt    = acc_q + {4'd0, PIXEL_IN};
    first_nxt  = first_pend_q ? PIXEL_IN : first_q;
    col_nxt    = col_base_q + side_a;
    blk_nxt    = blk_row_q + blk_stride;
  end

  // An address is driven on this edge (tags it for the read pipeline).
  always_comb begin
    issue = 1'b0;
    case (state_q)
      StIdle:    issue = START;
      StIssue:   issue = !last_issue;
      StPresent: issue = WIN_READY && !(last_col && last_row);
      default:   issue = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StIdle;
      shift_q      <= 2'd0;
      dx_q         <= 3'd0;
      dy_q         <= 3'd0;
      bx_q         <= 8'd0;
      by_q         <= 7'd0;
      col_base_q   <= '0;
      blk_row_q    <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      tag_q        <= '0;
      acc_q        <= 12'd0;
      first_q      <= 8'd0;
      first_pend_q <= 1'b0;
      win_sum_q    <= 12'd0;
      win_first_q  <= 8'd0;
      win_x_q      <= 8'd0;
      win_y_q      <= 7'd0;
      win_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tag_q  <= {tag_q[RD_LATENCY-1:0], issue};

      if (pix_vld) begin
        acc_q        <= sum_nxt;
        first_q      <= first_nxt;
        first_pend_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (START) begin
            shift_q      <= (SHIFT_FACTOR == 2'd3) ? 2'd2 : SHIFT_FACTOR;
            dx_q         <= 3'd0;
            dy_q         <= 3'd0;
            bx_q         <= 8'd0;
            by_q         <= 7'd0;
            col_base_q   <= '0;
            blk_row_q    <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            acc_q        <= 12'd0;
            first_pend_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StIssue;
          end
        end

        StIssue: begin
          if (last_issue) begin
            state_q <= StDrain;
          end else if (dx_q != side_m1) begin
            dx_q   <= dx_q + 3'd1;
            addr_q <= addr_q + ADDR_W'(1);
          end else begin
            dx_q   <= 3'd0;
            dy_q   <= dy_q + 3'd1;
            row_q  <= row_q + row_stride;
            addr_q <= row_q + row_stride + col_base_q;
          end
        end

        StDrain: begin
          if (drain_done) begin
            win_sum_q   <= sum_nxt;
            win_first_q <= first_nxt;
            win_x_q     <= bx_q;
            win_y_q     <= by_q;
            win_valid_q <= 1'b1;
            state_q     <= StPresent;
          end
        end

        StPresent: begin
          if (WIN_READY) begin
            win_valid_q <= 1'b0;
            if (last_col && last_row) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              dx_q         <= 3'd0;
              dy_q         <= 3'd0;
              acc_q        <= 12'd0;
              first_pend_q <= 1'b1;
              state_q      <= StIssue;
              if (last_col) begin
                bx_q       <= 8'd0;
                by_q       <= by_q + 7'd1;
                col_base_q <= '0;
                blk_row_q  <= blk_nxt;
                row_q      <= blk_nxt;
                addr_q     <= blk_nxt;
              end else begin
                bx_q       <= bx_q + 8'd1;
                col_base_q <= col_nxt;
                row_q      <= blk_row_q;
                addr_q     <= blk_row_q + col_nxt;
              end
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign R_ADDR    = addr_q;
  assign WIN_SUM   = win_sum_q;
  assign WIN_FIRST = win_first_q;
  assign WIN_X     = win_x_q;
  assign WIN_Y     = win_y_q;
  assign WIN_VALID = win_valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule
